// File: rtl/arp_static_resolver.sv
// arp_static_resolver: static ARP responder with a small fully-associative IP->MAC table
// Ports: clk/rst_n (async active-low); arp_request_* valid/ready/ip in;
// arp_response_* valid/ready/error/mac out; wr_en/wr_ip/wr_mac table write;
// clear_cache invalidates the table; local_ip/gateway_ip/subnet_mask config.
module arp_static_resolver #(
    parameter int CACHE_ADDR_WIDTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        arp_request_valid,
    output logic        arp_request_ready,
    input  logic [31:0] arp_request_ip,
    output logic        arp_response_valid,
    input  logic        arp_response_ready,
    output logic        arp_response_error,
    output logic [47:0] arp_response_mac,
    input  logic        wr_en,
    input  logic [31:0] wr_ip,
    input  logic [47:0] wr_mac,
    input  logic        clear_cache,
    input  logic [31:0] local_ip,
    input  logic [31:0] gateway_ip,
    input  logic [31:0] subnet_mask
);
    localparam int N = 1 << CACHE_ADDR_WIDTH;
    typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_t;
    state_t state;
    logic [31:0] req_ip;
    logic [31:0] tbl_ip [N];
    logic [47:0] tbl_mac [N];
    logic [N-1:0] tbl_valid;
    logic [CACHE_ADDR_WIDTH-1:0] ptr, wr_idx;
    logic [31:0] key;
    logic [47:0] hit_mac, lk_mac;
    logic hit, wr_hit, bcast, lk_err, do_wr;
    assign arp_request_ready = state == IDLE;
    assign bcast = (req_ip == '1) || ((req_ip | subnet_mask) == '1);
    // off-subnet destinations resolve through the gateway
    assign key = |((req_ip ^ local_ip) & subnet_mask) ? gateway_ip : req_ip;
    assign lk_err = !bcast && (key == '0 || !hit);
    assign lk_mac = bcast ? '1 : lk_err ? '0 : hit_mac;
    assign do_wr = wr_en && !clear_cache && wr_ip != '0;
    // scan downward so the lowest matching index wins
    always_comb begin
        hit = 1'b0;
        hit_mac = '0;
        wr_hit = 1'b0;
        wr_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (tbl_valid[i] && tbl_ip[i] == key) begin
                hit = 1'b1;
                hit_mac = tbl_mac[i];
            end
            if (tbl_valid[i] && tbl_ip[i] == wr_ip) begin
                wr_hit = 1'b1;
                wr_idx = CACHE_ADDR_WIDTH'(i);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (do_wr) begin
            tbl_ip[wr_hit ? wr_idx : ptr] <= wr_ip;
            tbl_mac[wr_hit ? wr_idx : ptr] <= wr_mac;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tbl_valid <= '0;
            ptr <= '0;
        end else if (clear_cache) begin
            tbl_valid <= '0;
            ptr <= '0;
        end else if (do_wr && !wr_hit) begin
            tbl_valid[ptr] <= 1'b1;
            ptr <= ptr + 1'b1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            req_ip <= '0;
            arp_response_valid <= 1'b0;
            arp_response_error <= 1'b0;
            arp_response_mac <= '0;
        end else begin
            case (state)
                IDLE: if (arp_request_valid) begin
                    req_ip <= arp_request_ip;
                    state <= LOOKUP;
                end
                LOOKUP: begin
                    arp_response_valid <= 1'b1;
                    arp_response_error <= lk_err;
                    arp_response_mac <= lk_mac;
                    state <= RESP;
                end
                RESP: if (arp_response_ready) begin
                    arp_response_valid <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_arp_static_resolver.sv
// tb_arp_static_resolver: directed self-checking bench for arp_static_resolver
module tb_arp_static_resolver;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        arp_request_valid = 1'b0;
    logic        arp_request_ready;
    logic [31:0] arp_request_ip = '0;
    logic        arp_response_valid;
    logic        arp_response_ready = 1'b0;
    logic        arp_response_error;
    logic [47:0] arp_response_mac;
    logic        wr_en = 1'b0;
    logic [31:0] wr_ip = '0;
    logic [47:0] wr_mac = '0;
    logic        clear_cache = 1'b0;
    logic [31:0] local_ip = 32'hC0A80180;
    logic [31:0] gateway_ip = 32'hC0A80101;
    logic [31:0] subnet_mask = 32'hFFFFFF00;
    int tests = 0;
    int fails = 0;
    arp_static_resolver #(.CACHE_ADDR_WIDTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .arp_request_valid(arp_request_valid), .arp_request_ready(arp_request_ready),
        .arp_request_ip(arp_request_ip),
        .arp_response_valid(arp_response_valid), .arp_response_ready(arp_response_ready),
        .arp_response_error(arp_response_error), .arp_response_mac(arp_response_mac),
        .wr_en(wr_en), .wr_ip(wr_ip), .wr_mac(wr_mac), .clear_cache(clear_cache),
        .local_ip(local_ip), .gateway_ip(gateway_ip), .subnet_mask(subnet_mask)
    );
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic wr(input logic [31:0] ip, input logic [47:0] mac);
        wr_en = 1'b1;
        wr_ip = ip;
        wr_mac = mac;
        tick;
        wr_en = 1'b0;
    endtask
    task automatic req(input string tag, input logic [31:0] ip, input logic e, input logic [47:0] m);
        arp_request_valid = 1'b1;
        arp_request_ip = ip;
        tick;
        arp_request_valid = 1'b0;
        chk({tag, ".lookup"}, {arp_request_ready, arp_response_valid}, 2'b00);
        tick;
        chk({tag, ".valid"}, arp_response_valid, 1'b1);
        chk({tag, ".err"}, arp_response_error, e);
        chk({tag, ".mac"}, arp_response_mac, m);
        arp_response_ready = 1'b1;
        tick;
        arp_response_ready = 1'b0;
        chk({tag, ".done"}, {arp_response_valid, arp_request_ready}, 2'b01);
    endtask
    initial begin
        #12;
        chk("rst.ready", arp_request_ready, 1'b1);
        chk("rst.valid", arp_response_valid, 1'b0);
        chk("rst.err", arp_response_error, 1'b0);
        chk("rst.mac", arp_response_mac, 48'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        // direct on-subnet hit
        wr(32'hC0A80164, 48'h020000000064);
        req("t1", 32'hC0A80164, 1'b0, 48'h020000000064);
        // gateway routing, then unresolved gateway, then zero key
        wr(32'hC0A80101, 48'h020000000001);
        req("t2.gw", 32'h0A000001, 1'b0, 48'h020000000001);
        gateway_ip = 32'hC0A801FE;
        req("t2.gwmiss", 32'h0A000001, 1'b1, 48'h0);
        gateway_ip = 32'h0;
        req("t2.key0", 32'h0A000001, 1'b1, 48'h0);
        gateway_ip = 32'hC0A80101;
        // broadcasts and plain miss
        req("t3.sub", 32'hC0A801FF, 1'b0, 48'hFFFFFFFFFFFF);
        req("t3.all", 32'hFFFFFFFF, 1'b0, 48'hFFFFFFFFFFFF);
        req("t3.miss", 32'hC0A80132, 1'b1, 48'h0);
        // eviction and in-place update
        clear_cache = 1'b1;
        tick;
        clear_cache = 1'b0;
        req("t4.clr", 32'hC0A80164, 1'b1, 48'h0);
        for (int i = 1; i <= 5; i++) wr(32'hC0A80110 + 32'(i), 48'h020000000010 + 48'(i));
        req("t4.ev1", 32'hC0A80111, 1'b1, 48'h0);
        req("t4.h2", 32'hC0A80112, 1'b0, 48'h020000000012);
        req("t4.h5", 32'hC0A80115, 1'b0, 48'h020000000015);
        wr(32'hC0A80112, 48'h0A0000000012);
        req("t4.upd2", 32'hC0A80112, 1'b0, 48'h0A0000000012);
        req("t4.h3", 32'hC0A80113, 1'b0, 48'h020000000013);
        req("t4.h4", 32'hC0A80114, 1'b0, 48'h020000000014);
        req("t4.h5b", 32'hC0A80115, 1'b0, 48'h020000000015);
        // the update consumed no slot, so the next new IP evicts the 2nd entry, not the 3rd
        wr(32'hC0A80116, 48'h020000000016);
        req("t4.h6", 32'hC0A80116, 1'b0, 48'h020000000016);
        req("t4.ev2", 32'hC0A80112, 1'b1, 48'h0);
        req("t4.h3b", 32'hC0A80113, 1'b0, 48'h020000000013);
        // backpressure with table activity during RESP
        arp_request_valid = 1'b1;
        arp_request_ip = 32'hC0A80113;
        tick;
        arp_request_valid = 1'b0;
        tick;
        for (int i = 0; i < 5; i++) begin
            wr_en = (i % 2) == 0;
            wr_ip = 32'hC0A80113;
            wr_mac = 48'hFFFFFFFF0000 + 48'(i);
            clear_cache = i == 3;
            tick;
            chk($sformatf("t5.hold%0d", i),
                {arp_response_valid, arp_response_error, arp_request_ready, arp_response_mac},
                {1'b1, 1'b0, 1'b0, 48'h020000000013});
        end
        wr_en = 1'b0;
        clear_cache = 1'b0;
        arp_response_ready = 1'b1;
        tick;
        arp_response_ready = 1'b0;
        chk("t5.done", {arp_response_valid, arp_request_ready}, 2'b01);
        // clear beats a simultaneous write
        clear_cache = 1'b1;
        wr_en = 1'b1;
        wr_ip = 32'hC0A80121;
        wr_mac = 48'h020000000021;
        tick;
        clear_cache = 1'b0;
        wr_en = 1'b0;
        req("t6.clrwins", 32'hC0A80121, 1'b1, 48'h0);
        // async reset during RESP
        wr(32'hC0A80122, 48'h020000000022);
        arp_request_valid = 1'b1;
        arp_request_ip = 32'hC0A80122;
        tick;
        arp_request_valid = 1'b0;
        tick;
        chk("t6.pre", {arp_response_valid, arp_response_mac}, {1'b1, 48'h020000000022});
        #1 rst_n = 1'b0;
        #1;
        chk("t6.rst", {arp_response_valid, arp_request_ready, arp_response_mac}, {1'b1 ^ 1'b1, 1'b1, 48'h0});
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        req("t6.empty", 32'hC0A80122, 1'b1, 48'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
